// File: rtl/fast_square_pkg.sv
// Shared definitions for the fast-square sweep sequencer.
// Holds the 3-bit FSM state encoding and the width of the completed-sweep
// counter so the controller, its step pulser and any bench agree on them.
package fast_square_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    SETTLE = 3'd2,
    RECORD = 3'd3,
    STEP   = 3'd4
  } state_t;

  localparam int SWEEP_CNT_W = 16;

endpackage

// File: rtl/fast_square_step_pulser.sv
// Pulse/gap generator for the STEP phase, decoded from the controller's
// shared state timer (the timer restarts at 0 when STEP is entered).
// Ports:
//   active - high while the controller is in STEP
//   timer  - shared state timer
//   pulse  - high for the first PULSE cycles of STEP
//   done   - high on the last cycle of PULSE+GAP
module fast_square_step_pulser #(
  parameter int CNT_W = 20,
  parameter int PULSE = 10,
  parameter int GAP   = 10
) (
  input  logic             active,
  input  logic [CNT_W-1:0] timer,
  output logic             pulse,
  output logic             done
);

  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(PULSE + GAP - 1);

  assign pulse = active && (timer < PULSE_END);
  assign done  = active && (timer == LAST_TICK);

endmodule

// File: rtl/fast_square_sweep_ctrl.sv
// Frequency-sweep sequencer for the fast-square receive chain.
// Walks RESET -> SETTLE -> RECORD -> STEP ... for a latched number of steps,
// with lock-gated settling, lock-loss restart, abort, resync and graceful stop.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   start/stop/abort    - one-cycle control pulses
//   freq_step_reset_in  - external resync, restarts the sweep at RESET
//   pll_locked          - synthesizer lock indicator
//   cfg_*               - sweep configuration, sampled only by start in IDLE
//   rx_record/rx_reset/rx_next, freq_step_out - RX path and synth controls
//   step_index, busy, sweep_done, sweep_count, lock_err - status
//   dbg_state           - current FSM state for observation
// Control pulses: start, stop, abort and freq_step_reset_in are sampled on
// every rising clock edge with no handshake; a pulse is acted on in the
// cycle it is seen and is never held or queued. All outputs are decoded from
// registers only, so there is no input-to-output combinational path.
module fast_square_sweep_ctrl
  import fast_square_pkg::*;
#(
  parameter int STEP_W           = 8,
  parameter int REC_W            = 16,
  parameter int CNT_W            = 20,
  parameter int RESET_TICKS      = 20'hFFFFF,
  parameter int SETTLE_TICKS     = 640,
  parameter int STEP_PULSE_TICKS = 10,
  parameter int STEP_GAP_TICKS   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   abort,
  input  logic                   freq_step_reset_in,
  input  logic                   pll_locked,
  input  logic [STEP_W-1:0]      cfg_num_steps,
  input  logic [REC_W-1:0]       cfg_record_ticks,
  input  logic                   cfg_continuous,
  output logic                   rx_record,
  output logic                   rx_reset,
  output logic                   rx_next,
  output logic                   freq_step_out,
  output logic [STEP_W-1:0]      step_index,
  output logic                   busy,
  output logic                   sweep_done,
  output logic [SWEEP_CNT_W-1:0] sweep_count,
  output logic                   lock_err,
  output state_t                 dbg_state
);

  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_TICKS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       timer_q, timer_d;
  logic [STEP_W-1:0]      step_index_q, step_index_d;
  logic [STEP_W-1:0]      num_steps_q, num_steps_d;
  logic [REC_W-1:0]       rec_ticks_q, rec_ticks_d;
  logic                   continuous_q, continuous_d;
  logic                   stop_pending_q, stop_pending_d;
  logic                   lock_err_q, lock_err_d;
  logic                   sweep_done_q, sweep_done_d;
  logic [SWEEP_CNT_W-1:0] sweep_count_q, sweep_count_d;

  logic state_change;
  logic rec_last;
  logic last_step;
  logic step_pulse;
  logic step_done;

  fast_square_step_pulser #(
    .CNT_W (CNT_W),
    .PULSE (STEP_PULSE_TICKS),
    .GAP   (STEP_GAP_TICKS)
  ) u_step_pulser (
    .active (state_q == STEP),
    .timer  (timer_q),
    .pulse  (step_pulse),
    .done   (step_done)
  );

  assign rec_last  = (timer_q == (CNT_W'(rec_ticks_q) - CNT_W'(1)));
  assign last_step = (step_index_q == (num_steps_q - STEP_W'(1)));

  always_comb begin
    state_d        = state_q;
    step_index_d   = step_index_q;
    num_steps_d    = num_steps_q;
    rec_ticks_d    = rec_ticks_q;
    continuous_d   = continuous_q;
    stop_pending_d = stop_pending_q;
    lock_err_d     = lock_err_q;
    sweep_done_d   = 1'b0;
    sweep_count_d  = sweep_count_q;
    state_change   = 1'b0;

    if (abort) begin
      // Abort in IDLE also swallows a simultaneous start.
      if (state_q != IDLE) begin
        state_d      = IDLE;
        state_change = 1'b1;
      end
    end else if (freq_step_reset_in && (state_q != IDLE)) begin
      state_d      = RESET;
      step_index_d = '0;
      state_change = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            num_steps_d    = (cfg_num_steps == '0) ? STEP_W'(1) : cfg_num_steps;
            rec_ticks_d    = (cfg_record_ticks == '0) ? REC_W'(1) : cfg_record_ticks;
            continuous_d   = cfg_continuous;
            lock_err_d     = 1'b0;
            stop_pending_d = 1'b0;
            step_index_d   = '0;
            state_d        = RESET;
            state_change   = 1'b1;
          end
        end
        RESET: begin
          if (timer_q == RESET_LAST) begin
            state_d      = SETTLE;
            state_change = 1'b1;
          end
        end
        SETTLE: begin
          // Timer holds the run of consecutive locked cycles.
          if (pll_locked && (timer_q == SETTLE_LAST)) begin
            state_d      = RECORD;
            state_change = 1'b1;
          end
        end
        RECORD: begin
          if (!pll_locked) begin
            lock_err_d   = 1'b1;
            step_index_d = '0;
            state_d      = RESET;
            state_change = 1'b1;
          end else if (rec_last) begin
            state_change = 1'b1;
            if (last_step) begin
              sweep_done_d  = 1'b1;
              sweep_count_d = sweep_count_q + SWEEP_CNT_W'(1);
              if (continuous_q && !stop_pending_q) begin
                state_d      = RESET;
                step_index_d = '0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              state_d      = STEP;
              step_index_d = step_index_q + STEP_W'(1);
            end
          end
        end
        STEP: begin
          if (step_done) begin
            state_d      = SETTLE;
            state_change = 1'b1;
          end
        end
        default: begin
          state_d      = IDLE;
          state_change = 1'b1;
        end
      endcase
    end

    if (stop && (state_q != IDLE)) begin
      stop_pending_d = 1'b1;
    end

    if (state_change || (state_q == IDLE)) begin
      timer_d = '0;
    end else if ((state_q == SETTLE) && !pll_locked) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      step_index_q   <= '0;
      num_steps_q    <= STEP_W'(1);
      rec_ticks_q    <= REC_W'(1);
      continuous_q   <= 1'b0;
      stop_pending_q <= 1'b0;
      lock_err_q     <= 1'b0;
      sweep_done_q   <= 1'b0;
      sweep_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      step_index_q   <= step_index_d;
      num_steps_q    <= num_steps_d;
      rec_ticks_q    <= rec_ticks_d;
      continuous_q   <= continuous_d;
      stop_pending_q <= stop_pending_d;
      lock_err_q     <= lock_err_d;
      sweep_done_q   <= sweep_done_d;
      sweep_count_q  <= sweep_count_d;
    end
  end

  assign rx_record     = (state_q == RECORD);
  assign rx_reset      = (state_q == RESET);
  assign rx_next       = (state_q == STEP) && (timer_q == '0);
  assign freq_step_out = step_pulse;
  assign step_index    = step_index_q;
  assign busy          = (state_q != IDLE);
  assign sweep_done    = sweep_done_q;
  assign sweep_count   = sweep_count_q;
  assign lock_err      = lock_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Bench for fast_square_sweep_ctrl: directed scenarios plus randomized
// traffic, checked every cycle against a phase/countdown model of the sweep.
module tb_fast_square_sweep_ctrl;
  import fast_square_pkg::*;

  localparam int RT = 16;
  localparam int ST = 8;
  localparam int PT = 3;
  localparam int GT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset, start, stop, abort, freq_step_reset_in, pll_locked;
  logic [7:0]  cfg_num_steps;
  logic [15:0] cfg_record_ticks;
  logic        cfg_continuous;
  logic        rx_record, rx_reset, rx_next, freq_step_out, busy, sweep_done, lock_err;
  logic [7:0]  step_index;
  logic [15:0] sweep_count;
  state_t      dbg_state;

  always #5 clock = ~clock;

  fast_square_sweep_ctrl #(
    .STEP_W(8), .REC_W(16), .CNT_W(20), .RESET_TICKS(RT), .SETTLE_TICKS(ST),
    .STEP_PULSE_TICKS(PT), .STEP_GAP_TICKS(GT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .abort(abort),
    .freq_step_reset_in(freq_step_reset_in), .pll_locked(pll_locked),
    .cfg_num_steps(cfg_num_steps), .cfg_record_ticks(cfg_record_ticks),
    .cfg_continuous(cfg_continuous), .rx_record(rx_record), .rx_reset(rx_reset),
    .rx_next(rx_next), .freq_step_out(freq_step_out), .step_index(step_index),
    .busy(busy), .sweep_done(sweep_done), .sweep_count(sweep_count),
    .lock_err(lock_err), .dbg_state(dbg_state)
  );

  // ---------------- behavioural model ----------------
  // Phase numbers follow the documented encoding; each phase keeps its own
  // countdown / run length instead of a shared timer.
  int          m_phase, m_left, m_run, m_age, m_num, m_rec, m_was;
  logic        m_cont, m_stop, m_err, m_done;
  logic [7:0]  m_idx;
  logic [15:0] m_cnt;
  logic [33:0] exp_q[$];

  task automatic go_reset();
    m_phase = 1;
    m_left  = RT;
    m_idx   = '0;
  endtask

  function automatic logic [33:0] model_vec();
    return {3'(m_phase), (m_phase == 3), (m_phase == 1), (m_phase == 4 && m_age == 0),
            (m_phase == 4 && m_age < PT), m_idx, (m_phase != 0), m_done, m_cnt, m_err};
  endfunction

  always @(posedge clock) begin
    m_done = 1'b0;
    if (reset) begin
      m_phase = 0; m_left = 0; m_run = 0; m_age = 0; m_num = 1; m_rec = 1;
      m_cont = 1'b0; m_stop = 1'b0; m_err = 1'b0; m_idx = '0; m_cnt = '0;
    end else begin
      m_was = m_phase;
      if (abort) begin
        m_phase = 0;
      end else if (freq_step_reset_in && m_phase != 0) begin
        go_reset();
      end else begin
        case (m_phase)
          0: if (start) begin
            m_num  = (cfg_num_steps == 0) ? 1 : int'(cfg_num_steps);
            m_rec  = (cfg_record_ticks == 0) ? 1 : int'(cfg_record_ticks);
            m_cont = cfg_continuous;
            m_err  = 1'b0;
            m_stop = 1'b0;
            go_reset();
          end
          1: begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_phase = 2; m_run = 0; end
          end
          2: begin
            m_run = pll_locked ? m_run + 1 : 0;
            if (m_run == ST) begin m_phase = 3; m_left = m_rec; end
          end
          3: begin
            if (!pll_locked) begin
              m_err = 1'b1;
              go_reset();
            end else begin
              m_left = m_left - 1;
              if (m_left == 0) begin
                if (int'(m_idx) == m_num - 1) begin
                  m_done = 1'b1;
                  m_cnt  = m_cnt + 16'd1;
                  if (m_cont && !m_stop) go_reset();
                  else m_phase = 0;
                end else begin
                  m_idx   = m_idx + 8'd1;
                  m_phase = 4;
                  m_age   = 0;
                end
              end
            end
          end
          4: begin
            m_age = m_age + 1;
            if (m_age == PT + GT) begin m_phase = 2; m_run = 0; end
          end
          default: ;
        endcase
      end
      if (stop && m_was != 0) m_stop = 1'b1;
    end
    exp_q.push_back(model_vec());
  end

  // ---------------- scoreboard / compare + monitor ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_rst = 0, n_rec = 0, n_next = 0, n_done = 0, n_idx_sum = 0;
  logic [33:0] want, got;
  string       lit_name[$];
  int          lit_act[$];
  int          lit_exp[$];
  string       lname;
  int          la, le;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {3'(dbg_state), rx_record, rx_reset, rx_next, freq_step_out, step_index,
              busy, sweep_done, sweep_count, lock_err};
      n_checks = n_checks + 1;
      if (got !== want) begin
        n_fail = n_fail + 1;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, got, want);
      end
    end
    while (lit_name.size() > 0) begin
      lname = lit_name.pop_front();
      la    = lit_act.pop_front();
      le    = lit_exp.pop_front();
      n_checks = n_checks + 1;
      if (la != le) begin
        n_fail = n_fail + 1;
        $display("FAIL %s got=%0d want=%0d", lname, la, le);
      end
    end
    n_rst     = n_rst + int'(rx_reset);
    n_rec     = n_rec + int'(rx_record);
    n_next    = n_next + int'(rx_next);
    n_done    = n_done + int'(sweep_done);
    n_idx_sum = n_idx_sum + (rx_record ? int'(step_index) : 0);
  end

  // ---------------- driver tasks ----------------
  task automatic lit(input string name, input int act, input int exp);
    lit_name.push_back(name);
    lit_act.push_back(act);
    lit_exp.push_back(exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input int ns, input int rt, input logic cont);
    cfg_num_steps    = 8'(ns);
    cfg_record_ticks = 16'(rt);
    cfg_continuous   = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic pulse_resync();
    freq_step_reset_in = 1'b1; tick(); freq_step_reset_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    if (busy) lit("idle_timeout", 1, 0);
  endtask

  // ---------------- scenarios ----------------
  int b_rst, b_rec, b_next, b_done, b_idx, c, k;

  task automatic snap();
    b_rst = n_rst; b_rec = n_rec; b_next = n_next; b_done = n_done; b_idx = n_idx_sum;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0; freq_step_reset_in = 1'b0;
    pll_locked = 1'b1; cfg_num_steps = '0; cfg_record_ticks = '0; cfg_continuous = 1'b0;
    do_reset();
    lit("reset_busy", int'(busy), 0);
    lit("reset_sweep_count", int'(sweep_count), 0);

    // single-shot, 3 steps x 5 record cycles
    snap();
    pulse_start(3, 5, 1'b0);
    wait_idle(600);
    lit("ss_rx_reset_cycles", n_rst - b_rst, 16);
    lit("ss_record_cycles", n_rec - b_rec, 15);
    lit("ss_rx_next_pulses", n_next - b_next, 2);
    lit("ss_sweep_done", n_done - b_done, 1);
    lit("ss_step_index_sum", n_idx_sum - b_idx, 15);
    lit("ss_sweep_count", int'(sweep_count), 1);
    lit("ss_busy", int'(busy), 0);

    // continuous with stop during sweep 2
    do_reset();
    snap();
    pulse_start(2, 5, 1'b1);
    k = 0;
    while (n_done - b_done < 1 && k < 600) begin tick(); k++; end
    k = 0;
    while (!rx_record && k < 200) begin tick(); k++; end
    pulse_stop();
    wait_idle(600);
    lit("cont_sweep_done", n_done - b_done, 2);
    lit("cont_sweep_count", int'(sweep_count), 2);

    // lock gating in SETTLE
    do_reset();
    pulse_start(1, 2, 1'b0);
    k = 0;
    while (rx_reset && k < 100) begin tick(); k++; end
    c = 0;
    while (!rx_record && c < 40) begin
      tick(); c++;
      pll_locked = (c == 6) ? 1'b0 : 1'b1;
    end
    pll_locked = 1'b1;
    lit("settle_gap_cycles", c, 15);
    wait_idle(200);

    // lock loss during step 1 RECORD
    do_reset();
    snap();
    pulse_start(3, 5, 1'b0);
    k = 0;
    while (!(rx_record && step_index == 8'd1) && k < 400) begin tick(); k++; end
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    lit("ll_lock_err", int'(lock_err), 1);
    lit("ll_rx_reset", int'(rx_reset), 1);
    lit("ll_step_index", int'(step_index), 0);
    lit("ll_no_done", n_done - b_done, 0);
    pulse_abort();
    lit("ll_err_held", int'(lock_err), 1);
    pulse_start(1, 1, 1'b0);
    lit("ll_err_cleared", int'(lock_err), 0);
    wait_idle(200);

    // abort during STEP, resync in IDLE and in RECORD
    do_reset();
    pulse_start(2, 3, 1'b0);
    k = 0;
    while (!freq_step_out && k < 400) begin tick(); k++; end
    pulse_abort();
    lit("ab_busy", int'(busy), 0);
    lit("ab_freq_step", int'(freq_step_out), 0);
    lit("ab_rx_any", int'(rx_record | rx_reset | rx_next), 0);
    lit("ab_index_held", int'(step_index), 1);
    pulse_resync();
    lit("rs_idle_busy", int'(busy), 0);
    pulse_start(2, 3, 1'b0);
    k = 0;
    while (!(rx_record && step_index == 8'd1) && k < 400) begin tick(); k++; end
    pulse_resync();
    lit("rs_rx_reset", int'(rx_reset), 1);
    lit("rs_step_index", int'(step_index), 0);
    pulse_abort();

    // zero configuration
    do_reset();
    snap();
    pulse_start(0, 0, 1'b0);
    wait_idle(200);
    lit("zero_record_cycles", n_rec - b_rec, 1);
    lit("zero_rx_next", n_next - b_next, 0);
    lit("zero_sweep_done", n_done - b_done, 1);
    lit("zero_sweep_count", int'(sweep_count), 1);

    // randomized traffic against the model
    do_reset();
    for (int r = 0; r < 6; r++) begin
      pulse_start($urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 400; i++) begin
        pll_locked         = ($urandom_range(0, 19) != 0);
        start              = ($urandom_range(0, 49) == 0);
        stop               = ($urandom_range(0, 99) == 0);
        abort              = ($urandom_range(0, 199) == 0);
        freq_step_reset_in = ($urandom_range(0, 199) == 0);
        cfg_num_steps      = 8'($urandom_range(0, 3));
        cfg_record_ticks   = 16'($urandom_range(0, 4));
        cfg_continuous     = 1'($urandom_range(0, 1));
        tick();
      end
      start = 1'b0; stop = 1'b0; freq_step_reset_in = 1'b0; pll_locked = 1'b1;
      pulse_abort();
    end

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/fast_square_sweep_ctrl.md
Name: fast_square_sweep_ctrl

Overview:
Parametrised frequency-sweep sequencer for the fast-square receive chain. It drives the external synthesizer step line and the RX capture path through a reset / settle / record / step sequence. Compared with the fixed-schedule controller, it adds runtime-configurable step count and record length, single-shot or continuous sweeps, and PLL-lock-gated settling. It also adds lock-loss recovery, abort, graceful stop, and sweep status outputs.

Parameters:
STEP_W, 8, width of step count/index
REC_W, 16, width of record length counter
CNT_W, 20, width of shared state timer
RESET_TICKS, 20'hFFFFF, cycles spent in RESET
SETTLE_TICKS, 640, consecutive locked cycles required before recording
STEP_PULSE_TICKS, 10, freq_step_out high time per step
STEP_GAP_TICKS, 10, low time after the step pulse before settling

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a sweep from IDLE
stop  in  1  one-cycle pulse; finish the current sweep, then go IDLE
abort  in  1  immediate return to IDLE
freq_step_reset_in  in  1  external resync; restart the sweep at RESET
pll_locked  in  1  synthesizer lock indicator
cfg_num_steps  in  STEP_W  steps per sweep (0 treated as 1)
cfg_record_ticks  in  REC_W  record cycles per step (0 treated as 1)
cfg_continuous  in  1  1 = repeat sweeps until stop or abort
rx_record  out  1  capture enable
rx_reset  out  1  RX chain reset
rx_next  out  1  one-cycle advance-bin pulse
freq_step_out  out  1  synthesizer step line
step_index  out  STEP_W  current step, 0-based
busy  out  1  high in any state except IDLE
sweep_done  out  1  one-cycle pulse at sweep end
sweep_count  out  16  completed sweeps, wraps at 16'hFFFF->0
lock_err  out  1  sticky lock-loss flag

Behaviour:
- States: IDLE, RESET, SETTLE, RECORD, STEP.
- Outputs are decoded from registered state and counters. They are Moore outputs with no input-to-output combinational path.
- Timer: one CNT_W counter, cleared on every state change.
- Reset values: state IDLE; all outputs 0; step_index 0; sweep_count 0; lock_err 0; stop_pending 0.
- IDLE:
  - start latches cfg_num_steps, cfg_record_ticks and cfg_continuous, applying the zero->1 rule.
  - start also clears lock_err and stop_pending, then moves to RESET next cycle.
  - cfg_* inputs are ignored outside IDLE.
- RESET:
  - rx_reset=1, step_index=0.
  - After exactly RESET_TICKS cycles in RESET, go to SETTLE.
- SETTLE:
  - The timer increments only while pll_locked=1 and clears on any pll_locked=0 cycle.
  - When it reaches SETTLE_TICKS, go to RECORD.
- RECORD:
  - rx_record=1 for exactly the latched record_ticks cycles.
  - If pll_locked=0 in any RECORD cycle: set lock_err, go to RESET next cycle; the sweep restarts from step 0 and sweep_done is not pulsed.
  - On the last record cycle with step_index==num_steps-1:
    - Pulse sweep_done on the following cycle and increment sweep_count.
    - Go to RESET if continuous and not stop_pending; otherwise go to IDLE.
  - On the last record cycle otherwise: go to STEP.
- STEP:
  - First cycle: rx_next=1 and step_index increments.
  - freq_step_out=1 for the first STEP_PULSE_TICKS cycles, then 0 for STEP_GAP_TICKS cycles, then go to SETTLE.
- stop: sets stop_pending in any non-IDLE state. It takes effect only at sweep end; in single-shot mode it has no additional effect.
- Priority (high to low): reset > abort > freq_step_reset_in > lock-loss > start/normal transitions.
  - abort forces IDLE next cycle. step_index holds its last value, and sweep_count and lock_err hold.
  - freq_step_reset_in in IDLE is ignored; in any other state it forces RESET.
- Simultaneous start+abort in IDLE: stay IDLE.
- Counter arithmetic is unsigned. Comparisons use the full latched widths; step_index never exceeds num_steps-1.

Decomposition:
- Package fast_square_pkg holds the state encoding constants (IDLE=0, RESET=1, SETTLE=2, RECORD=3, STEP=4, 3-bit) and the sweep_count width (16).
- One natural sub-module, fast_square_step_pulser: a timer-driven pulse/gap generator used by STEP, with parameters PULSE and GAP and a done output.

Test Plan:
- Bench configuration for all scenarios: RESET_TICKS=16, SETTLE_TICKS=8, pulse=3, gap=2.
- Single-shot: num_steps=3, record_ticks=5, pll_locked=1. Required response: rx_reset high 16 cycles; three rx_record bursts of 5 cycles; two rx_next pulses; step_index 0,1,2; sweep_done once; sweep_count=1; IDLE with busy=0.
- Continuous with stop: num_steps=2, cfg_continuous=1, stop pulsed mid-sweep 2. Required response: sweep_done pulses exactly twice; sweep_count=2; then IDLE.
- Lock gating: drop pll_locked for 1 cycle after 6 SETTLE cycles. Required response: RECORD entered only after 8 further consecutive locked cycles.
- Lock loss: pll_locked=0 during step 1 RECORD. Required response: lock_err=1; next cycle RESET with step_index=0; no sweep_done. A later start clears lock_err.
- Abort/resync: abort during STEP. Required response: next cycle IDLE with freq_step_out=0, rx_* all 0. A separate run with freq_step_reset_in during RECORD returns to RESET next cycle; freq_step_reset_in in IDLE does nothing.
- Zero configuration: cfg_num_steps=0, cfg_record_ticks=0. Required response: one step with a 1-cycle record burst, then sweep_done.
